// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes and the multicycle controller state encoding.
package rv32i_pkg;

    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_L     = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_S     = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B     = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_FAULT   = 3'd7
    } mc_state_t;

    // True for every opcode this core implements.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_R, OP_I, OP_L, OP_S, OP_B,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_mc_ctrl_if.sv
// Decoder/datapath-facing signal bundle of the multicycle sequencing controller.
interface rv32i_mc_ctrl_if #(parameter int unsigned CNT_W = 32);

    logic [31:0]      instr_code;
    logic             reg_wr_en_dec;
    logic             d_wr_en_dec;
    logic             branch_taken;
    logic             mem_ready;
    logic             ir_en;
    logic             pc_en;
    logic             pc_take;
    logic             reg_wr_en;
    logic             d_wr_en;
    logic             d_rd_en;
    logic             fault;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret;

    // Controller side: consumes decode/datapath status, drives the write enables.
    modport master (
        input  instr_code, reg_wr_en_dec, d_wr_en_dec, branch_taken, mem_ready,
        output ir_en, pc_en, pc_take, reg_wr_en, d_wr_en, d_rd_en, fault, state_o, instret
    );

    // Datapath side.
    modport slave (
        output instr_code, reg_wr_en_dec, d_wr_en_dec, branch_taken, mem_ready,
        input  ir_en, pc_en, pc_take, reg_wr_en, d_wr_en, d_rd_en, fault, state_o, instret
    );

endinterface

// File: rtl/mc_timeout_cnt.sv
// Loadable down-counter bounding how long a data-memory access may stall.
module mc_timeout_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expiry_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Expires on the last permitted stall cycle; a limit of 1 expires immediately.
    assign expiry_c = (cnt_q <= W'(1));

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// RV32I multicycle sequencer: steps FETCH/DECODE/EXECUTE/MEM/WB and gates the
// architectural write enables so each fires once per instruction.
module rv32i_mc_ctrl
    import rv32i_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic              clk,
    input logic              reset,
    rv32i_mc_ctrl_if.master  bus
);

    localparam int unsigned TO_W = 8;

    mc_state_t             state_q, state_d;
    logic [CNT_W-1:0]      instret_q;
    logic [OPCODE_W-1:0]   op;
    logic                  is_load, is_store;
    logic                  ir_en_c, pc_en_c, pc_take_c, reg_wr_en_c, d_wr_en_c, d_rd_en_c;
    logic                  retire_c, cnt_load_c, cnt_en_c, cnt_clr_c, expiry_c;
    logic                  unused_ir_hi;

    assign op           = bus.instr_code[OPCODE_W-1:0];
    assign unused_ir_hi = ^bus.instr_code[31:OPCODE_W];
    assign is_load      = (op == OP_L);
    assign is_store     = (op == OP_S);

    mc_timeout_cnt #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr_c),
        .load     (cnt_load_c),
        .en       (cnt_en_c),
        .load_val (TO_W'(MEM_TIMEOUT - 1)),
        .expiry_c (expiry_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Next state and per-state enables; reset forces every enable low.
    always_comb begin
        state_d     = state_q;
        ir_en_c     = 1'b0;
        pc_en_c     = 1'b0;
        pc_take_c   = 1'b0;
        reg_wr_en_c = 1'b0;
        d_wr_en_c   = 1'b0;
        d_rd_en_c   = 1'b0;
        retire_c    = 1'b0;
        cnt_load_c  = 1'b0;
        cnt_en_c    = 1'b0;
        cnt_clr_c   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_en_c = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = is_legal(op) ? ST_EXECUTE : ST_FAULT;
            ST_EXECUTE: begin
                if (op == OP_B) begin
                    pc_en_c   = 1'b1;
                    pc_take_c = bus.branch_taken;
                    retire_c  = 1'b1;
                    state_d   = ST_FETCH;
                end else if (is_load || is_store) begin
                    cnt_load_c = 1'b1;
                    state_d    = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                d_rd_en_c = is_load;
                d_wr_en_c = is_store && bus.d_wr_en_dec;
                if (bus.mem_ready) begin
                    cnt_clr_c = 1'b1;
                    if (is_load) begin
                        state_d = ST_WB;
                    end else begin
                        pc_en_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (expiry_c) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            ST_WB: begin
                reg_wr_en_c = bus.reg_wr_en_dec;
                pc_en_c     = 1'b1;
                pc_take_c   = (op == OP_JAL) || (op == OP_JALR);
                retire_c    = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
        if (reset) begin
            state_d     = ST_FETCH;
            ir_en_c     = 1'b0;
            pc_en_c     = 1'b0;
            pc_take_c   = 1'b0;
            reg_wr_en_c = 1'b0;
            d_wr_en_c   = 1'b0;
            d_rd_en_c   = 1'b0;
            retire_c    = 1'b0;
            cnt_load_c  = 1'b0;
            cnt_en_c    = 1'b0;
            cnt_clr_c   = 1'b0;
        end
    end

    assign bus.ir_en     = ir_en_c;
    assign bus.pc_en     = pc_en_c;
    assign bus.pc_take   = pc_take_c;
    assign bus.reg_wr_en = reg_wr_en_c;
    assign bus.d_wr_en   = d_wr_en_c;
    assign bus.d_rd_en   = d_rd_en_c;
    assign bus.fault     = (state_q == ST_FAULT);
    assign bus.state_o   = state_q;
    assign bus.instret   = instret_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed cycle-by-cycle check of rv32i_mc_ctrl against a per-cycle expectation queue.
module tb_rv32i_mc_ctrl;

    localparam int unsigned CNT_W = 32;

    // Enable vector bit order: {ir_en, pc_en, pc_take, reg_wr_en, d_wr_en, d_rd_en}
    localparam logic [5:0] EN_NONE = 6'b000000;
    localparam logic [5:0] EN_IR   = 6'b100000;
    localparam logic [5:0] EN_PC   = 6'b010000;
    localparam logic [5:0] EN_TAKE = 6'b001000;
    localparam logic [5:0] EN_RW   = 6'b000100;
    localparam logic [5:0] EN_DW   = 6'b000010;
    localparam logic [5:0] EN_DR   = 6'b000001;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A103;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_JAL = 32'h008000EF;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    typedef struct packed {
        logic [2:0]       st;
        logic [5:0]       en;
        logic             flt;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    rv32i_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rv32i_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_ir(input logic [31:0] ins, input logic rw, input logic dw);
        bus.instr_code    = ins;
        bus.reg_wr_en_dec = rw;
        bus.d_wr_en_dec   = dw;
    endtask

    // Queue this cycle's expectation, sample mid-cycle, compare, advance to the next negedge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] en,
                       input logic flt, input logic [CNT_W-1:0] ret);
        exp_t e;
        logic [5:0] got_en;
        sb.push_back('{st: st, en: en, flt: flt, ret: ret});
        #2;
        e      = sb.pop_front();
        got_en = {bus.ir_en, bus.pc_en, bus.pc_take, bus.reg_wr_en, bus.d_wr_en, bus.d_rd_en};
        n_checks++;
        assert (bus.state_o === e.st) else begin
            n_fail++;
            $error("FAIL %s state got %0d exp %0d", tag, bus.state_o, e.st);
        end
        n_checks++;
        assert (got_en === e.en) else begin
            n_fail++;
            $error("FAIL %s enables got %b exp %b", tag, got_en, e.en);
        end
        n_checks++;
        assert (bus.fault === e.flt) else begin
            n_fail++;
            $error("FAIL %s fault got %b exp %b", tag, bus.fault, e.flt);
        end
        n_checks++;
        assert (bus.instret === e.ret) else begin
            n_fail++;
            $error("FAIL %s instret got %0d exp %0d", tag, bus.instret, e.ret);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        load_ir(32'h0, 1'b0, 1'b0);
        bus.branch_taken = 1'b0;
        bus.mem_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset held: FETCH, enables suppressed, counters cleared
        cyc("reset", 3'd0, EN_NONE, 1'b0, 0);
        reset = 1'b0;

        // R-type add
        cyc("add_f",  3'd0, EN_IR, 1'b0, 0);
        load_ir(I_ADD, 1'b1, 1'b0);
        bus.mem_ready = 1'b1;
        cyc("add_d",  3'd1, EN_NONE, 1'b0, 0);
        cyc("add_e",  3'd2, EN_NONE, 1'b0, 0);
        cyc("add_wb", 3'd4, EN_PC | EN_RW, 1'b0, 0);

        // Load with two wait states
        cyc("lw_f", 3'd0, EN_IR, 1'b0, 1);
        load_ir(I_LW, 1'b1, 1'b0);
        bus.mem_ready = 1'b0;
        cyc("lw_d",  3'd1, EN_NONE, 1'b0, 1);
        cyc("lw_e",  3'd2, EN_NONE, 1'b0, 1);
        cyc("lw_m0", 3'd3, EN_DR, 1'b0, 1);
        cyc("lw_m1", 3'd3, EN_DR, 1'b0, 1);
        bus.mem_ready = 1'b1;
        cyc("lw_m2", 3'd3, EN_DR, 1'b0, 1);
        bus.mem_ready = 1'b0;
        cyc("lw_wb", 3'd4, EN_PC | EN_RW, 1'b0, 1);

        // Branch taken, then not taken
        cyc("beq_f", 3'd0, EN_IR, 1'b0, 2);
        load_ir(I_BEQ, 1'b0, 1'b0);
        bus.branch_taken = 1'b1;
        cyc("beq_d", 3'd1, EN_NONE, 1'b0, 2);
        cyc("beq_e", 3'd2, EN_PC | EN_TAKE, 1'b0, 2);
        cyc("bnt_f", 3'd0, EN_IR, 1'b0, 3);
        bus.branch_taken = 1'b0;
        cyc("bnt_d", 3'd1, EN_NONE, 1'b0, 3);
        cyc("bnt_e", 3'd2, EN_PC, 1'b0, 3);

        // JAL writes rd and takes the target
        cyc("jal_f", 3'd0, EN_IR, 1'b0, 4);
        load_ir(I_JAL, 1'b1, 1'b0);
        cyc("jal_d",  3'd1, EN_NONE, 1'b0, 4);
        cyc("jal_e",  3'd2, EN_NONE, 1'b0, 4);
        cyc("jal_wb", 3'd4, EN_PC | EN_TAKE | EN_RW, 1'b0, 4);

        // Store, zero wait states
        cyc("sw_f", 3'd0, EN_IR, 1'b0, 5);
        load_ir(I_SW, 1'b0, 1'b1);
        cyc("sw_d", 3'd1, EN_NONE, 1'b0, 5);
        cyc("sw_e", 3'd2, EN_NONE, 1'b0, 5);
        bus.mem_ready = 1'b1;
        cyc("sw_m", 3'd3, EN_PC | EN_DW, 1'b0, 5);
        bus.mem_ready = 1'b0;

        // Reset lands while a store is waiting in MEM
        cyc("swr_f",  3'd0, EN_IR, 1'b0, 6);
        cyc("swr_d",  3'd1, EN_NONE, 1'b0, 6);
        cyc("swr_e",  3'd2, EN_NONE, 1'b0, 6);
        cyc("swr_m0", 3'd3, EN_DW, 1'b0, 6);
        reset = 1'b1;
        cyc("swr_rst", 3'd3, EN_NONE, 1'b0, 6);
        reset = 1'b0;

        // Store that never gets mem_ready: three write cycles, then sticky FAULT
        cyc("to_f",  3'd0, EN_IR, 1'b0, 0);
        cyc("to_d",  3'd1, EN_NONE, 1'b0, 0);
        cyc("to_e",  3'd2, EN_NONE, 1'b0, 0);
        cyc("to_m0", 3'd3, EN_DW, 1'b0, 0);
        cyc("to_m1", 3'd3, EN_DW, 1'b0, 0);
        cyc("to_m2", 3'd3, EN_DW, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready    = i[0];
            bus.branch_taken = i[1];
            cyc("to_fault", 3'd7, EN_NONE, 1'b1, 0);
        end
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        reset = 1'b1;
        cyc("to_rst", 3'd7, EN_NONE, 1'b1, 0);
        reset = 1'b0;

        // Illegal opcode traps in DECODE
        cyc("ill_f", 3'd0, EN_IR, 1'b0, 0);
        load_ir(I_BAD, 1'b1, 1'b1);
        cyc("ill_d", 3'd1, EN_NONE, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("ill_fault", 3'd7, EN_NONE, 1'b1, 0);
        end
        reset = 1'b1;
        cyc("ill_rst", 3'd7, EN_NONE, 1'b1, 0);
        reset = 1'b0;
        cyc("post_f", 3'd0, EN_IR, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
